// File: rtl/dma_tester_pkg.sv
// Shared definitions for the DMA stream testers: FSM encoding, lane count and
// the tkeep mask used on the final beat of a frame.
package dma_tester_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } tester_state_t;

  localparam int DW_DEFAULT = 32;
  localparam int BYTES      = DW_DEFAULT / 8;
  localparam int MAX_BYTES  = 16;

  // Remainder of the frame length in lanes; zero means the last beat is full.
  function automatic logic [MAX_BYTES-1:0] keep_mask(input int unsigned rem,
                                                     input int unsigned nbytes);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (rem == 0) m[i] = (i < nbytes);
      else          m[i] = (i < rem);
    end
    return m;
  endfunction

endpackage

// File: rtl/dma_pattern_lane_gen.sv
// Builds one beat of incrementing bytes starting at base; lanes whose keep bit
// is clear are forced to zero.
module dma_pattern_lane_gen
  import dma_tester_pkg::*;
#(
  parameter int NB = BYTES
) (
  input  logic [7:0]      base,
  input  logic [NB-1:0]   keep,
  output logic [NB*8-1:0] data
);

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign data[gi*8 +: 8] = keep[gi] ? 8'(base + 8'(gi)) : 8'h00;
  end

endmodule

// File: rtl/dma_stream_pattern_gen.sv
// AXI4-Stream frame source for DMA S2MM bring-up: emits a configurable number
// of incrementing-byte frames with correct tkeep/tlast and busy/done status.
module dma_stream_pattern_gen
  import dma_tester_pkg::*;
#(
  parameter logic [3:0] ID   = 4'h0,
  parameter int          DW   = DW_DEFAULT,
  parameter int          GAP  = 4,
  parameter int          LENW = 16
) (
  input  logic              tester_clk,
  input  logic              tester_resetn,
  input  logic              cfg_start,
  input  logic [LENW-1:0]   cfg_len_bytes,
  input  logic [7:0]        cfg_frames,
  input  logic [7:0]        cfg_seed,
  input  logic              cfg_abort,
  output logic              status_busy,
  output logic              status_done,
  output logic [7:0]        status_frame_cnt,
  output logic              tester_o_tvalid,
  input  logic              tester_o_tready,
  output logic [DW-1:0]     tester_o_tdata,
  output logic [DW/8-1:0]   tester_o_tkeep,
  output logic [3:0]        tester_o_tdest,
  output logic              tester_o_tlast
);

  localparam int NB = DW / 8;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  tester_state_t   state_reg, state_next;
  logic [7:0]      frames_reg, seed_reg, base_reg, frame_cnt_reg;
  logic [LENW-1:0] last_idx_reg, beat_idx_reg;
  logic [4:0]      rem_reg;
  logic [GW-1:0]   gap_cnt_reg;
  logic            abort_seen_reg, busy_reg, done_reg;
  logic            tvalid_reg, tlast_reg;
  logic [DW-1:0]   tdata_reg;
  logic [NB-1:0]   tkeep_reg;
  logic [3:0]      tdest_reg;

  logic [LENW:0]   cfg_beats;
  logic [LENW-1:0] cfg_last_idx;
  logic [4:0]      cfg_rem;

  logic            start_run, load_beat, new_frame, frame_end, drop_valid, go_done, run_end;
  logic [7:0]      load_base;
  logic [LENW-1:0] load_idx, last_sel;
  logic [4:0]      rem_sel;
  logic            load_last;
  logic [NB-1:0]   load_keep;
  logic [DW-1:0]   load_data;

  // Widened by one bit so that ceil() of a full-scale length cannot overflow.
  assign cfg_beats    = ({1'b0, cfg_len_bytes} + (LENW+1)'(NB - 1)) / (LENW+1)'(NB);
  assign cfg_last_idx = LENW'(cfg_beats - 1'b1);
  assign cfg_rem      = 5'(cfg_len_bytes % LENW'(NB));
  assign run_end      = ((frame_cnt_reg + 8'd1) == frames_reg);

  always_comb begin
    state_next = state_reg;
    start_run  = 1'b0;
    load_beat  = 1'b0;
    new_frame  = 1'b0;
    frame_end  = 1'b0;
    drop_valid = 1'b0;
    load_base  = base_reg + 8'(NB);
    load_idx   = beat_idx_reg + 1'b1;
    rem_sel    = rem_reg;
    last_sel   = last_idx_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (cfg_start && (cfg_len_bytes != '0) && (cfg_frames != 8'd0)) begin
          state_next = S_SEND;
          start_run  = 1'b1;
          load_beat  = 1'b1;
          load_base  = cfg_seed;
          load_idx   = '0;
          rem_sel    = cfg_rem;
          last_sel   = cfg_last_idx;
        end
      end
      S_SEND: begin
        if (tvalid_reg && tester_o_tready) begin
          if (tlast_reg) begin
            frame_end = 1'b1;
            if (run_end || abort_seen_reg || cfg_abort) begin
              state_next = S_DONE;
              drop_valid = 1'b1;
            end else if (GAP == 0) begin
              new_frame = 1'b1;
              load_beat = 1'b1;
              load_base = seed_reg + 8'd1;
              load_idx  = '0;
            end else begin
              state_next = S_GAP;
              drop_valid = 1'b1;
            end
          end else begin
            load_beat = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_reg == GW'(GAP - 1)) begin
          if (abort_seen_reg || cfg_abort) begin
            state_next = S_DONE;
          end else begin
            state_next = S_SEND;
            new_frame  = 1'b1;
            load_beat  = 1'b1;
            load_base  = seed_reg + 8'd1;
            load_idx   = '0;
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    load_last = (load_idx == last_sel);
    load_keep = load_last ? NB'(keep_mask(32'(rem_sel), NB)) : '1;
  end

  assign go_done = (state_next == S_DONE) && (state_reg != S_DONE);

  dma_pattern_lane_gen #(.NB(NB)) u_lane_gen (
    .base (load_base),
    .keep (load_keep),
    .data (load_data)
  );

  always_ff @(posedge tester_clk or negedge tester_resetn) begin
    if (!tester_resetn) state_reg <= S_IDLE;
    else                state_reg <= state_next;
  end

  always_ff @(posedge tester_clk or negedge tester_resetn) begin
    if (!tester_resetn) begin
      frames_reg     <= '0;
      seed_reg       <= '0;
      base_reg       <= '0;
      frame_cnt_reg  <= '0;
      last_idx_reg   <= '0;
      beat_idx_reg   <= '0;
      rem_reg        <= '0;
      gap_cnt_reg    <= '0;
      abort_seen_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      tvalid_reg     <= 1'b0;
      tlast_reg      <= 1'b0;
      tdata_reg      <= '0;
      tkeep_reg      <= '0;
      tdest_reg      <= '0;
    end else begin
      tdest_reg <= ID;
      done_reg  <= go_done;
      if (start_run)    busy_reg <= 1'b1;
      else if (go_done) busy_reg <= 1'b0;

      if (start_run) begin
        frames_reg    <= cfg_frames;
        seed_reg      <= cfg_seed;
        rem_reg       <= cfg_rem;
        last_idx_reg  <= cfg_last_idx;
        frame_cnt_reg <= '0;
      end else begin
        if (frame_end) frame_cnt_reg <= frame_cnt_reg + 8'd1;
        if (new_frame) seed_reg      <= seed_reg + 8'd1;
      end

      // Abort is remembered so a short pulse still stops after the frame.
      if (start_run)                  abort_seen_reg <= 1'b0;
      else if (busy_reg && cfg_abort) abort_seen_reg <= 1'b1;

      if ((state_next == S_GAP) && (state_reg != S_GAP)) gap_cnt_reg <= '0;
      else if (state_reg == S_GAP)                        gap_cnt_reg <= gap_cnt_reg + 1'b1;

      if (load_beat) begin
        tvalid_reg   <= 1'b1;
        tdata_reg    <= load_data;
        tkeep_reg    <= load_keep;
        tlast_reg    <= load_last;
        base_reg     <= load_base;
        beat_idx_reg <= load_idx;
      end else if (drop_valid) begin
        tvalid_reg <= 1'b0;
        tdata_reg  <= '0;
        tkeep_reg  <= '0;
        tlast_reg  <= 1'b0;
      end
    end
  end

  assign status_busy      = busy_reg;
  assign status_done      = done_reg;
  assign status_frame_cnt = frame_cnt_reg;
  assign tester_o_tvalid  = tvalid_reg;
  assign tester_o_tdata   = tdata_reg;
  assign tester_o_tkeep   = tkeep_reg;
  assign tester_o_tdest   = tdest_reg;
  assign tester_o_tlast   = tlast_reg;

endmodule
